image_average_divider: RTL and testbench

Sequential divider that converts accumulated per-pixel sums into the average image. It consumes a stream of 24-bit pixel sums produced by the image-accumulation stage, divides each by the number of accumulated images, and emits one 8-bit average pixel per sum. It sits between the accumulator and the classifier's template store. A full frame of NUM_PIXELS pixels is processed per `start`.

---
 rtl/image_average_divider_if.sv | 28 ++
 rtl/image_average_divider.sv | 170 +++++++++++++++++
 tb/tb_image_average_divider.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_average_divider_if.sv
// Stream bundle between the image accumulator, the average divider and the template store.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the sum side, out_valid/out_ready on the pixel side.
interface image_average_divider_if #(
    parameter int SUM_W = 24,
    parameter int PIX_W = 8,
    parameter int IDX_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic [IDX_W-1:0] out_index;

    // Producer/consumer side (accumulator feeding sums, store taking pixels)
    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_pixel, out_index
    );

    // Divider side
    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_pixel, out_index
    );
endinterface

// File: rtl/image_average_divider.sv
// Divides each accumulated pixel sum by the image count, one frame of NUM_PIXELS per start.
// Latency: out_valid rises SUM_W+1 cycles after the sum is accepted; SUM_W+3 cycles per pixel minimum.
// Backpressure: one pixel in flight; in_ready stays low until the held output is taken by out_ready.
module image_average_divider #(
    parameter int NUM_PIXELS = 784,
    parameter int SUM_W      = 24,
    parameter int CNT_W      = 16,
    parameter int PIX_W      = 8,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    image_average_divider_if.slave bus
);

    localparam int                ITER_W    = $clog2(SUM_W + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(SUM_W);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PIXELS - 1);
    localparam logic [PIX_W-1:0]  PIX_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_divisor;
    logic [SUM_W-1:0]   r_dividend;
    logic [CNT_W:0]     r_rem;
    logic [SUM_W-1:0]   r_quot;
    logic [ITER_W-1:0]  r_iter;
    logic [IDX_W-1:0]   r_index;
    logic [PIX_W-1:0]   r_pixel;
    logic               r_done;

    logic               w_start;
    logic               w_accept;
    logic               w_handoff;
    logic               w_last_pix;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    logic [CNT_W+1:0]   w_trial;
    logic [CNT_W+1:0]   w_diff;
    logic               w_ge;
    logic [CNT_W:0]     w_rem_next;
    logic [PIX_W-1:0]   w_pixel;

    // Next-state and handshake decode; all control is a function of the current state
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = (r_state != S_IDLE);
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_handoff    = 1'b0;
        w_last_pix   = (r_index == LAST_IDX);
        case (r_state)
            S_IDLE: begin
                w_start = start;
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid) begin
                    w_state_next = S_DIV;
                end
            end
            S_DIV: begin
                // Extra cycle after the last quotient bit latches the saturated pixel
                if (r_iter == LAST_ITER) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                w_handoff   = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_next = w_last_pix ? S_IDLE : S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One restoring step: the partial remainder is always below the divisor, so the
    // trial value fits CNT_W+1 bits and the top bit of the difference is its sign
    always_comb begin
        w_trial    = {r_rem, r_dividend[SUM_W-1]};
        w_diff     = w_trial - {2'b00, r_divisor};
        w_ge       = ~w_diff[CNT_W+1];
        w_rem_next = w_ge ? w_diff[CNT_W:0] : w_trial[CNT_W:0];
        if (r_divisor == '0) begin
            w_pixel = '0;
        end else if (|r_quot[SUM_W-1:PIX_W]) begin
            w_pixel = PIX_MAX;
        end else begin
            w_pixel = r_quot[PIX_W-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Divider datapath, pixel index and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_divisor  <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_iter     <= '0;
            r_index    <= '0;
            r_pixel    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_handoff && w_last_pix;
            if (w_start) begin
                r_divisor <= count;
                r_index   <= '0;
            end
            if (w_accept) begin
                r_dividend <= bus.in_sum;
                r_rem      <= '0;
                r_quot     <= '0;
                r_iter     <= '0;
            end
            if (r_state == S_DIV) begin
                if (r_iter != LAST_ITER) begin
                    r_dividend <= {r_dividend[SUM_W-2:0], 1'b0};
                    r_rem      <= w_rem_next;
                    r_quot     <= {r_quot[SUM_W-2:0], w_ge};
                    r_iter     <= r_iter + ITER_W'(1);
                end else begin
                    r_pixel <= w_pixel;
                end
            end
            if (w_handoff && !w_last_pix) begin
                r_index <= r_index + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pixel = r_pixel;
    assign bus.out_index = r_index;
    assign busy          = w_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_image_average_divider.sv
// Self-checking bench for image_average_divider against an arithmetic reference average.
// Latency: checks SUM_W+1 cycles from accept to out_valid for every pixel.
// Backpressure: exercises random in_valid/out_ready gaps and a held output.
module tb_image_average_divider;

    localparam int NPIX  = 784;
    localparam int SUM_W = 24;
    localparam int CNT_W = 16;
    localparam int PIX_W = 8;
    localparam int IDX_W = 10;
    localparam int LAT   = SUM_W + 1;
    localparam int TMO   = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_cnt   = 0;

    image_average_divider_if #(.SUM_W(SUM_W), .PIX_W(PIX_W), .IDX_W(IDX_W)) bus ();

    image_average_divider #(
        .NUM_PIXELS(NPIX), .SUM_W(SUM_W), .CNT_W(CNT_W), .PIX_W(PIX_W), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // Reference: floor(sum/count), clamped to 8 bits, zero for a zero count
    function automatic logic [PIX_W-1:0] ref_avg(input longint s, input longint c);
        longint q;
        if (c == 0) return '0;
        q = s / c;
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        start        = 1'b0;
        count        = '0;
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_frame(input logic [CNT_W-1:0] c);
        start = 1'b1;
        count = c;
        tick();
        start = 1'b0;
    endtask

    // Offer one sum, wait for its result; reports accept-to-valid latency
    task automatic accept_and_wait(input logic [SUM_W-1:0] s, input int in_gap,
                                   output int lat, output bit ok);
        int n;
        int t_acc;
        ok  = 1'b0;
        lat = -1;
        repeat (in_gap) tick();
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        n = 0;
        while (!bus.in_ready && n < TMO) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready=%0b, required 1 within %0d cycles", bus.in_ready, TMO);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        t_acc        = cyc;
        bus.in_valid = 1'b0;
        bus.in_sum   = SUM_W'($urandom);
        n = 0;
        while (!bus.out_valid && n < TMO) begin
            tick();
            n++;
        end
        if (!bus.out_valid) begin
            compared++;
            mismatched++;
            $display("FAIL out_valid_timeout: out_valid=%0b, required 1 within %0d cycles", bus.out_valid, TMO);
            return;
        end
        lat = cyc - t_acc;
        ok  = 1'b1;
    endtask

    task automatic do_pixel(input logic [SUM_W-1:0] s, input int in_gap, input int out_gap,
                            output logic [PIX_W-1:0] pix, output logic [IDX_W-1:0] idx,
                            output int lat, output bit ok);
        pix = '0;
        idx = '0;
        accept_and_wait(s, in_gap, lat, ok);
        if (!ok) return;
        repeat (out_gap) tick();
        bus.out_ready = 1'b1;
        pix = bus.out_pixel;
        idx = bus.out_index;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; count = '0;
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.out_ready = 1'b0;
        repeat (2) tick();
        compared += 6;
        if (bus.in_ready !== 1'b0)  begin mismatched++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
        if (bus.out_pixel !== '0)   begin mismatched++; $display("FAIL rst_out_pixel: got %0d want 0", bus.out_pixel); end
        if (bus.out_index !== '0)   begin mismatched++; $display("FAIL rst_out_index: got %0d want 0", bus.out_index); end
        if (busy !== 1'b0)          begin mismatched++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (done !== 1'b0)          begin mismatched++; $display("FAIL rst_done: got %0b want 0", done); end
        reset = 1'b1;
        repeat (3) tick();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [SUM_W-1:0] sums [4];
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        bit               ok;
        sums = '{24'd0, 24'd4, 24'd1020, 24'd7};
        do_reset();
        start_frame(16'd4);
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_load_ready: got %0b want 1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) count = 16'd1;
            do_pixel(sums[i], 0, 0, pix, idx, lat, ok);
            if (!ok) break;
            compared += 3;
            if (pix !== ref_avg(sums[i], 4)) begin mismatched++; $display("FAIL basic_pix[%0d]: got %0d want %0d", i, pix, ref_avg(sums[i], 4)); end
            if (idx !== IDX_W'(i))           begin mismatched++; $display("FAIL basic_idx[%0d]: got %0d want %0d", i, idx, i); end
            if (lat != LAT)                  begin mismatched++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_saturate();
        logic [CNT_W-1:0] cs [7];
        logic [SUM_W-1:0] ss [7];
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        bit               ok;
        cs = '{16'd1, 16'd3, 16'd3, 16'd7, 16'd65535, 16'd65535, 16'd65535};
        ss = '{24'd300, 24'd766, 24'd764, 24'hFFFFFF, 24'hFFFFFF, 24'd16711425, 24'd16711424};
        for (int k = 0; k < 7; k++) begin
            do_reset();
            start_frame(cs[k]);
            do_pixel(ss[k], 0, 0, pix, idx, lat, ok);
            if (!ok) continue;
            compared += 2;
            if (pix !== ref_avg(ss[k], cs[k])) begin mismatched++; $display("FAIL sat_pix[%0d]: got %0d want %0d", k, pix, ref_avg(ss[k], cs[k])); end
            if (idx !== '0)                    begin mismatched++; $display("FAIL sat_idx[%0d]: got %0d want 0", k, idx); end
        end
    endtask

    task automatic test_random_values();
        logic [CNT_W-1:0] c;
        logic [SUM_W-1:0] s;
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        bit               ok;
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) begin
                c = CNT_W'($urandom_range(1, 300));
                s = SUM_W'(int'(c) * $urandom_range(0, 300) + $urandom_range(0, int'(c) - 1));
            end else begin
                c = CNT_W'($urandom);
                s = SUM_W'($urandom);
            end
            do_reset();
            start_frame(c);
            do_pixel(s, 0, 0, pix, idx, lat, ok);
            if (!ok) continue;
            compared += 2;
            if (pix !== ref_avg(s, c)) begin mismatched++; $display("FAIL rand_pix[%0d]: sum %0d cnt %0d got %0d want %0d", k, s, c, pix, ref_avg(s, c)); end
            if (lat != LAT)            begin mismatched++; $display("FAIL rand_lat[%0d]: got %0d want %0d", k, lat, LAT); end
        end
    endtask

    task automatic test_backpressure();
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        bit               ok;
        do_reset();
        start_frame(16'd5);
        do_pixel(24'd53, 0, 0, pix, idx, lat, ok);
        if (!ok) return;
        compared++;
        if (pix !== ref_avg(53, 5)) begin mismatched++; $display("FAIL bp_pix0: got %0d want %0d", pix, ref_avg(53, 5)); end
        accept_and_wait(24'd1234, 0, lat, ok);
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.in_sum   = 24'd99;
        for (int k = 0; k < 10; k++) begin
            compared += 4;
            if (bus.out_valid !== 1'b1)            begin mismatched++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, bus.out_valid); end
            if (bus.out_pixel !== ref_avg(1234, 5)) begin mismatched++; $display("FAIL bp_hold_pix[%0d]: got %0d want %0d", k, bus.out_pixel, ref_avg(1234, 5)); end
            if (bus.out_index !== IDX_W'(1))       begin mismatched++; $display("FAIL bp_hold_idx[%0d]: got %0d want 1", k, bus.out_index); end
            if (bus.in_ready !== 1'b0)             begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        compared += 2;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_valid_drop: got %0b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1)  begin mismatched++; $display("FAIL bp_ready_rise: got %0b want 1", bus.in_ready); end
        do_pixel(24'd99, 0, 0, pix, idx, lat, ok);
        if (!ok) return;
        compared += 3;
        if (pix !== ref_avg(99, 5)) begin mismatched++; $display("FAIL bp_next_pix: got %0d want %0d", pix, ref_avg(99, 5)); end
        if (idx !== IDX_W'(2))      begin mismatched++; $display("FAIL bp_next_idx: got %0d want 2", idx); end
        if (lat != LAT)             begin mismatched++; $display("FAIL bp_next_lat: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_zero_count();
        logic [SUM_W-1:0] s;
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        int               d0;
        bit               ok;
        do_reset();
        start_frame(16'd0);
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            s = SUM_W'($urandom);
            do_pixel(s, 0, 0, pix, idx, lat, ok);
            if (!ok) break;
            compared += 3;
            if (pix !== ref_avg(s, 0)) begin mismatched++; $display("FAIL zero_pix[%0d]: got %0d want %0d", i, pix, ref_avg(s, 0)); end
            if (idx !== IDX_W'(i))     begin mismatched++; $display("FAIL zero_idx[%0d]: got %0d want %0d", i, idx, i); end
            if (lat != LAT)            begin mismatched++; $display("FAIL zero_lat[%0d]: got %0d want %0d", i, lat, LAT); end
        end
        if (!ok) return;
        compared += 2;
        if (done !== 1'b1) begin mismatched++; $display("FAIL zero_done: got %0b want 1", done); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL zero_busy: got %0b want 0", busy); end
        tick();
        compared += 2;
        if (done !== 1'b0)        begin mismatched++; $display("FAIL zero_done_width: got %0b want 0", done); end
        if (done_cnt - d0 != 1)   begin mismatched++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_full_frame();
        logic [SUM_W-1:0] s;
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        int               ig;
        int               og;
        int               d0;
        bit               ok;
        do_reset();
        start_frame(16'd10);
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            s  = SUM_W'(10 * (i % 256));
            ig = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            og = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if (i != NPIX - 1 && $urandom_range(0, 4) == 0) begin
                start = 1'b1;
                count = CNT_W'($urandom);
            end
            do_pixel(s, ig, og, pix, idx, lat, ok);
            start = 1'b0;
            if (!ok) break;
            compared += 3;
            if (pix !== ref_avg(s, 10)) begin mismatched++; $display("FAIL frame_pix[%0d]: got %0d want %0d", i, pix, ref_avg(s, 10)); end
            if (idx !== IDX_W'(i))      begin mismatched++; $display("FAIL frame_idx[%0d]: got %0d want %0d", i, idx, i); end
            if (lat != LAT)             begin mismatched++; $display("FAIL frame_lat[%0d]: got %0d want %0d", i, lat, LAT); end
        end
        if (!ok) return;
        compared += 2;
        if (done !== 1'b1) begin mismatched++; $display("FAIL frame_done: got %0b want 1", done); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL frame_busy: got %0b want 0", busy); end
        // start raised in the done cycle must be taken
        start_frame(16'd3);
        compared += 4;
        if (done !== 1'b0)          begin mismatched++; $display("FAIL frame_done_width: got %0b want 0", done); end
        if (done_cnt - d0 != 1)     begin mismatched++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - d0); end
        if (busy !== 1'b1)          begin mismatched++; $display("FAIL frame_restart_busy: got %0b want 1", busy); end
        if (bus.in_ready !== 1'b1)  begin mismatched++; $display("FAIL frame_restart_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_div();
        logic [SUM_W-1:0] s;
        logic [PIX_W-1:0] pix;
        logic [IDX_W-1:0] idx;
        int               lat;
        int               n;
        bit               ok;
        do_reset();
        start_frame(16'd7);
        for (int i = 0; i < 5; i++) begin
            s = SUM_W'(7 * (i + 3) + 1);
            do_pixel(s, 0, 0, pix, idx, lat, ok);
            if (!ok) return;
            compared += 2;
            if (pix !== ref_avg(s, 7)) begin mismatched++; $display("FAIL mid_pix[%0d]: got %0d want %0d", i, pix, ref_avg(s, 7)); end
            if (idx !== IDX_W'(i))     begin mismatched++; $display("FAIL mid_idx[%0d]: got %0d want %0d", i, idx, i); end
        end
        bus.in_valid = 1'b1;
        bus.in_sum   = 24'd700;
        n = 0;
        while (!bus.in_ready && n < TMO) begin tick(); n++; end
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %0b want 1", busy); end
        reset = 1'b0;
        #1;
        compared += 6;
        if (bus.in_ready !== 1'b0)  begin mismatched++; $display("FAIL mid_rst_in_ready: got %0b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_out_valid: got %0b want 0", bus.out_valid); end
        if (bus.out_pixel !== '0)   begin mismatched++; $display("FAIL mid_rst_out_pixel: got %0d want 0", bus.out_pixel); end
        if (bus.out_index !== '0)   begin mismatched++; $display("FAIL mid_rst_out_index: got %0d want 0", bus.out_index); end
        if (busy !== 1'b0)          begin mismatched++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
        if (done !== 1'b0)          begin mismatched++; $display("FAIL mid_rst_done: got %0b want 0", done); end
        tick();
        reset = 1'b1;
        tick();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_idle_after: got %0b want 0", busy); end
        start_frame(16'd2);
        do_pixel(24'd9, 0, 0, pix, idx, lat, ok);
        if (!ok) return;
        compared += 3;
        if (pix !== ref_avg(9, 2)) begin mismatched++; $display("FAIL mid_new_pix: got %0d want %0d", pix, ref_avg(9, 2)); end
        if (idx !== '0)            begin mismatched++; $display("FAIL mid_new_idx: got %0d want 0", idx); end
        if (lat != LAT)            begin mismatched++; $display("FAIL mid_new_lat: got %0d want %0d", lat, LAT); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_random_values();
        test_backpressure();
        test_reset_mid_div();
        test_zero_count();
        test_full_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "global timeout");
    end

endmodule
